poci_burst_readout: RTL and testbench

Parametrised serial readout engine for the chip's register-read path. It is the next generation of the single-word mux-plus-shift readout. It selects a register by address, snapshots it into a shift register, and shifts it out on `serial_out` one bit per `sclk`. It adds a chip-select framed transaction, multi-word bursts with auto-increment and wrap, selectable bit order, and out-of-range detection.

---
 rtl/poci_burst_readout.sv | 152 +++++++++++++++
 tb/tb_poci_burst_readout.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poci_burst_readout.sv
// Serial register readout engine: chip-select framed bursts of register words,
// auto-incrementing address with wrap, selectable bit order, sticky address error.
module poci_burst_readout #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 59,
    parameter int ADDR_W    = $clog2(NUM_REGS + 1),
    parameter int LEN_W     = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         sclk,
    input  logic                         rstn,
    input  logic                         cs_n,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [LEN_W-1:0]             burst_len,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
    output logic                         serial_out,
    output logic                         busy,
    output logic                         done,
    output logic                         addr_err
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    words_left_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                serial_q;
    logic                busy_q;
    logic                done_q;
    logic                addr_err_q;

    logic [ADDR_W-1:0]   next_addr_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic [DATA_W-1:0]   load_word_s;
    logic                load_err_s;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a == {ADDR_W{1'b0}}) || (int'(a) > NUM_REGS);
    endfunction

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a,
                                                  input logic [NUM_REGS*DATA_W-1:0] regs);
        logic [DATA_W-1:0] w;
        w = {DATA_W{1'b0}};
        if (!addr_bad(a)) begin
            w = regs[(int'(a) - 1) * DATA_W +: DATA_W];
        end else begin
            w = {DATA_W{1'b0}};
        end
        return w;
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    // Remaining bits move toward the output end so the next bit is always at the same position.
    function automatic logic [DATA_W-1:0] shift_rest(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Address and word to load: the frame start address from IDLE, the successor mid-burst.
    always_comb begin
        next_addr_s = ((addr_q == {ADDR_W{1'b0}}) || (int'(addr_q) >= NUM_REGS))
                      ? ADDR_W'(1) : addr_q + ADDR_W'(1);
        load_addr_s = (state_q == IDLE) ? start_addr : next_addr_s;
        load_word_s = word_at(load_addr_s, reg_data);
        load_err_s  = addr_bad(load_addr_s);
    end

    // Frame FSM with registered serial, busy, done and error outputs.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            words_left_q <= {LEN_W{1'b0}};
            bit_cnt_q    <= {CNT_W{1'b0}};
            shreg_q      <= {DATA_W{1'b0}};
            serial_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cs_n) begin
                        addr_q       <= start_addr;
                        words_left_q <= (burst_len == {LEN_W{1'b0}}) ? LEN_W'(1) : burst_len;
                        shreg_q      <= shift_rest(load_word_s);
                        serial_q     <= first_bit(load_word_s);
                        bit_cnt_q    <= CNT_W'(1);
                        addr_err_q   <= load_err_s;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end else begin
                        serial_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_n) begin
                        serial_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (bit_cnt_q < LAST_BIT) begin
                        serial_q  <= first_bit(shreg_q);
                        shreg_q   <= shift_rest(shreg_q);
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end else if (words_left_q > LEN_W'(1)) begin
                        words_left_q <= words_left_q - LEN_W'(1);
                        addr_q       <= next_addr_s;
                        shreg_q      <= shift_rest(load_word_s);
                        serial_q     <= first_bit(load_word_s);
                        bit_cnt_q    <= CNT_W'(1);
                        addr_err_q   <= addr_err_q | load_err_s;
                    end else begin
                        serial_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    serial_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= cs_n ? IDLE : WAIT;
                end
                default: begin
                    serial_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_poci_burst_readout.sv
// Directed bench for poci_burst_readout: an LSB-first and an MSB-first instance share stimulus
// and are checked every cycle against a bit-index model, plus literal per-test expectations.
module tb_poci_burst_readout;

    localparam int DW = 8;
    localparam int NR = 59;
    localparam int AW = 6;
    localparam int LW = 6;

    logic              sclk = 1'b0;
    logic              rstn = 1'b1;
    logic              cs_n = 1'b1;
    logic [AW-1:0]     start_addr = '0;
    logic [LW-1:0]     burst_len = '0;
    logic [NR*DW-1:0]  reg_data;

    logic ser_l, busy_l, done_l, err_l;
    logic ser_m, busy_m, done_m, err_m;

    int n_cmp = 0;
    int n_bad = 0;

    poci_burst_readout #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .LEN_W(LW), .MSB_FIRST(1'b0)) dut (
        .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .start_addr(start_addr), .burst_len(burst_len),
        .reg_data(reg_data), .serial_out(ser_l), .busy(busy_l), .done(done_l), .addr_err(err_l));

    poci_burst_readout #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .LEN_W(LW), .MSB_FIRST(1'b1)) dut_m (
        .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .start_addr(start_addr), .burst_len(burst_len),
        .reg_data(reg_data), .serial_out(ser_m), .busy(busy_m), .done(done_m), .addr_err(err_m));

    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_run = 1'b0;
    bit        m_wait = 1'b0;
    int        m_k = 0;
    int        m_n = 0;
    int        m_addr = 0;
    logic [7:0] m_word = 8'h00;
    logic      e_ser_l = 1'b0, e_ser_m = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    task automatic model_emit();
        if (m_k % DW == 0) begin
            if (m_k != 0) m_addr = (m_addr >= 1 && m_addr < NR) ? m_addr + 1 : 1;
            m_word = (m_addr >= 1 && m_addr <= NR) ? reg_data[(m_addr - 1) * DW +: DW] : 8'h00;
        end
        e_ser_l = m_word[m_k % DW];
        e_ser_m = m_word[DW - 1 - (m_k % DW)];
        m_k++;
    endtask

    always @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            m_run = 1'b0; m_wait = 1'b0; m_k = 0; m_n = 0;
            e_ser_l = 1'b0; e_ser_m = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else begin
            e_done = 1'b0;
            if (m_run) begin
                if (cs_n) begin
                    m_run = 1'b0; e_ser_l = 1'b0; e_ser_m = 1'b0; e_busy = 1'b0;
                end else if (m_k == m_n * DW) begin
                    m_run = 1'b0; m_wait = 1'b1;
                    e_ser_l = 1'b0; e_ser_m = 1'b0; e_busy = 1'b0; e_done = 1'b1;
                end else begin
                    model_emit();
                end
            end else if (m_wait) begin
                if (cs_n) m_wait = 1'b0;
            end else if (!cs_n) begin
                m_n    = (int'(burst_len) == 0) ? 1 : int'(burst_len);
                m_addr = int'(start_addr);
                m_k    = 0;
                m_run  = 1'b1;
                e_busy = 1'b1;
                e_err  = (m_addr == 0 || m_addr > NR);
                model_emit();
            end
        end
    end

    always @(negedge sclk) begin
        check("ser_lsb",  {31'd0, ser_l},  {31'd0, e_ser_l});
        check("ser_msb",  {31'd0, ser_m},  {31'd0, e_ser_m});
        check("busy",     {30'd0, busy_l, busy_m}, {30'd0, e_busy, e_busy});
        check("done",     {30'd0, done_l, done_m}, {30'd0, e_done, e_done});
        check("addr_err", {30'd0, err_l, err_m},   {30'd0, e_err, e_err});
    end

    // ---------------- directed stimulus ----------------
    task automatic start_frame(input int a, input int l);
        @(negedge sclk);
        start_addr = AW'(a);
        burst_len  = LW'(l);
        cs_n       = 1'b0;
    endtask

    task automatic collect(input int n, output logic [31:0] vl, output logic [31:0] vm,
                           output int busy_cnt);
        vl = '0; vm = '0; busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            vl[i] = ser_l;
            vm[i] = ser_m;
            busy_cnt += int'(busy_l);
        end
    endtask

    task automatic end_frame();
        @(negedge sclk);
        cs_n = 1'b1;
        repeat (2) @(negedge sclk);
    endtask

    task automatic check_done(input string name);
        @(negedge sclk);
        check({name, "_done"}, {31'd0, done_l}, 32'd1);
        check({name, "_idle"}, {30'd0, busy_l, ser_l}, 32'd0);
    endtask

    logic [31:0] vl, vm;
    int          bc;
    logic        b0l, b0m;

    initial begin
        for (int k = 1; k <= NR; k++) reg_data[(k - 1) * DW +: DW] = DW'(k);
        #1 rstn = 1'b0;
        repeat (2) @(negedge sclk);
        check("reset_outs", {28'd0, ser_l, busy_l, done_l, err_l}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge sclk);

        // single word, register 2
        start_frame(2, 1);
        collect(8, vl, vm, bc);
        check("single_lsb", vl, 32'h02);
        check("single_msb", vm, 32'h40);
        check("single_busy_cnt", bc, 32'd8);
        check("single_err", {31'd0, err_l}, 32'd0);
        check_done("single");
        end_frame();

        // wrapping burst 58,59,1 with cs_n held low afterwards
        start_frame(58, 3);
        collect(24, vl, vm, bc);
        check("wrap_lsb", vl, 32'h013B3A);
        check("wrap_busy_cnt", bc, 32'd24);
        check_done("wrap");
        repeat (5) @(negedge sclk);
        check("wrap_hold_no_restart", {31'd0, busy_l}, 32'd0);
        end_frame();

        // burst_len 0 behaves as one word
        start_frame(20, 0);
        collect(8, vl, vm, bc);
        check("len0_lsb", vl, 32'h14);
        check_done("len0");
        end_frame();

        // reserved address 0
        start_frame(0, 1);
        collect(8, vl, vm, bc);
        check("addr0_data", vl, 32'h00);
        check("addr0_err", {31'd0, err_l}, 32'd1);
        check_done("addr0");
        end_frame();
        check("addr0_err_sticky", {31'd0, err_l}, 32'd1);

        // out-of-range address 60 then wrap to register 1
        start_frame(60, 2);
        collect(16, vl, vm, bc);
        check("addr60_data", vl, 32'h0100);
        check("addr60_err", {31'd0, err_l}, 32'd1);
        check_done("addr60");
        end_frame();

        // error clears at next frame start
        start_frame(3, 1);
        @(negedge sclk);
        check("err_clear", {31'd0, err_l}, 32'd0);
        collect(7, vl, vm, bc);
        check_done("addr3");
        end_frame();

        // abort after 5 bits
        start_frame(5, 1);
        collect(5, vl, vm, bc);
        check("abort_partial", vl, 32'h05);
        cs_n = 1'b1;
        @(negedge sclk);
        check("abort_outs", {29'd0, ser_l, busy_l, done_l}, 32'd0);
        repeat (4) @(negedge sclk);
        start_frame(9, 1);
        collect(8, vl, vm, bc);
        check("after_abort", vl, 32'h09);
        check_done("after_abort");
        end_frame();

        // asynchronous reset during word 2 (register 11, bit 3 = 1 on the LSB instance)
        start_frame(10, 3);
        collect(12, vl, vm, bc);
        check("pre_reset_state", {30'd0, ser_l, busy_l}, 32'd3);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_outs", {26'd0, ser_l, busy_l, done_l, ser_m, busy_m, done_m}, 32'd0);
        @(negedge sclk);
        cs_n = 1'b1;
        @(negedge sclk);
        rstn = 1'b1;
        start_frame(4, 1);
        collect(8, vl, vm, bc);
        check("post_reset", vl, 32'h04);
        check_done("post_reset");
        end_frame();

        // MSB-first with snapshot: register 7 changes after its load edge
        reg_data[6 * DW +: DW] = 8'hA5;
        start_frame(7, 1);
        @(negedge sclk);
        b0l = ser_l;
        b0m = ser_m;
        reg_data[6 * DW +: DW] = 8'h00;
        collect(7, vl, vm, bc);
        check("snap_msb", {24'd0, vm[6:0], b0m}, 32'hA5);
        check("snap_lsb", {24'd0, vl[6:0], b0l}, 32'hA5);
        check_done("snap");
        end_frame();

        // same register after the change reads back as zero
        start_frame(7, 1);
        collect(8, vl, vm, bc);
        check("snap_after", vl, 32'h00);
        check_done("snap_after");
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
